aes64_round_ctrl: RTL and testbench
===================================

# aes64_round_ctrl

Iterative round sequencer for the 64-bit AES datapath. It accepts one plaintext or ciphertext block over a valid/ready handshake and holds it in an internal state register. It then drives the external combinational round function (SubBytes/ShiftRows/MixColumns/AddRoundKey, module `aes64_round`) once per cycle for NUM_ROUNDS+1 iterations and returns the result over a second valid/ready handshake. It sits between the block-level I/O wrapper and `aes64_round`, and it also supplies the round-key index to the key store.

## Interface
- NUM_ROUNDS, 10, number of full rounds; iteration 0 is initial key whitening, so NUM_ROUNDS+1 iterations total; legal range 1..15
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input block valid
- in_ready  out  1  controller can accept a block
- in_data  in  64  input block, byte 0 = [63:56]
- in_decrypt  in  1  mode, sampled with in_data; 1 = decrypt
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  64  result block
- rnd_state_o  out  64  current state to `aes64_round`
- rnd_result_i  in  64  next state from `aes64_round`, combinational
- rnd_idx_o  out  4  round-key index to key store and datapath
- rnd_first_o  out  1  current iteration is whitening-only
- rnd_last_o  out  1  current iteration is the final round; MixColumns skipped
- rnd_dec_o  out  1  latched mode, selects inverse transforms
- busy  out  1  FSM not IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch state_q←in_data and dec_q←in_decrypt, clear step←0, go to RUN.
- RUN:
  - Each cycle: state_q←rnd_result_i and step←step+1.
  - When step==NUM_ROUNDS, perform the final capture and go to DONE with step←0.
  - in_valid is ignored; in_ready=0.
- DONE:
  - out_valid=1 and out_data=state_q.
  - On out_ready, go to IDLE.
  - state_q is held stable while out_ready=0.
- Round index:
  - Encrypt: rnd_idx_o = step.
  - Decrypt: rnd_idx_o = NUM_ROUNDS−step.
- Iteration flags:
  - rnd_first_o = (FSM==RUN && step==0).
  - rnd_last_o = (FSM==RUN && step==NUM_ROUNDS).
  - Both are 0 outside RUN.
- Continuous outputs: rnd_state_o=state_q and rnd_dec_o=dec_q at all times.
- Counter width: 4 bits, sized ROUND_IDX_W=$clog2(16). Subtraction is unsigned and never underflows because step ≤ NUM_ROUNDS.
- No abort. A block, once accepted, always completes.

## Timing
- Reset:
  - While rst=1: FSM=IDLE, in_ready=0, out_valid=0, busy=0, state_q=0, dec_q=0, step=0.
  - From the first cycle after rst deasserts: in_ready=1.
  - rst asserted mid-RUN or in DONE discards the block; out_valid=0 on the next edge.
- Latency:
  - Accept at edge T.
  - RUN covers edges T+1..T+NUM_ROUNDS+1.
  - out_valid=1 in the cycle after edge T+NUM_ROUNDS+1.
  - With the default NUM_ROUNDS=10, that is 11 cycles after accept.
- Throughput: one block per NUM_ROUNDS+3 cycles at best, since DONE→IDLE costs one cycle.
  - in_ready is never asserted in the same cycle as out_valid.
  - There is no simultaneous accept/return path by design.
- Handshake rules:
  - out_valid stays asserted and out_data stays stable until out_ready is seen.
  - in_data is sampled only on in_valid&&in_ready.
- rnd_result_i is sampled on every RUN edge and must settle within one cycle.

## Structure
- Shared package `aes64_pkg`:
  - ctrl_state_t enum {IDLE, RUN, DONE}.
  - AES64_NUM_ROUNDS=10.
  - ROUND_IDX_W=4.
  - STATE_W=64.
- No sub-module. The step counter and FSM are inline.
- `aes64_round` is a sibling instance wired at the top level, not instantiated here.

## Test plan
Use a stub round function: rnd_result_i = rnd_state_o + rnd_idx_o + 1.
- **Reset:** hold rst 3 cycles mid-block → out_valid=0, busy=0, in_ready=1 on the first cycle after release.
- **Encrypt:**
  - Stimulus: in_data=64'h0, in_decrypt=0.
  - Required: out_data=64'h42 (sum 0..10 = 55, plus 11 increments = 66) exactly 11 cycles after accept.
  - Required: rnd_idx_o sequence 0,1,…,10, with rnd_first_o only at idx 0 and rnd_last_o only at idx 10.
- **Decrypt:**
  - Stimulus: in_data=64'h100, in_decrypt=1.
  - Required: rnd_idx_o sequence 10,9,…,0, with rnd_first_o only at idx 10 and rnd_last_o only at idx 0.
  - Required: out_data=64'h142 and rnd_dec_o=1 throughout RUN.
- **Backpressure:** out_ready=0 for 5 cycles in DONE → out_valid and out_data stable throughout; in_ready=0 until 1 cycle after out_ready=1.
- **Ignored input:** in_valid pulsed with in_data=64'hDEAD during RUN → no effect on the result or on the round count.
- **Back-to-back blocks:** two blocks with out_ready tied 1 → second accept exactly 13 cycles after the first; both results correct.

Source files
------------

// File: rtl/aes64_pkg.sv
// Shared definitions for the 64-bit AES round controller slice.
// Contents: controller FSM state type, default round count, counter and state widths.
package aes64_pkg;

  localparam int unsigned AES64_NUM_ROUNDS = 10;
  localparam int unsigned ROUND_IDX_W      = $clog2(16);
  localparam int unsigned STATE_W          = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/aes64_round_ctrl_if.sv
// Block-in / block-out handshake bundle of the AES round controller.
// Signals: in_valid/in_ready/in_data/in_decrypt (block in),
//          out_valid/out_ready/out_data (block out).
// master: wrapper side that offers blocks and consumes results.
// slave:  the round controller.
interface aes64_round_ctrl_if;
  import aes64_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_data;
  logic               in_decrypt;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes64_round_ctrl.sv
// Iterative round sequencer: accepts one block, runs the external combinational
// round function for NUM_ROUNDS+1 iterations (iteration 0 = key whitening) and
// returns the result.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           block in/out handshakes (slave side)
//   rnd_state_o   current state to the round function
//   rnd_result_i  next state from the round function (combinational)
//   rnd_idx_o     round-key index (descending when decrypting)
//   rnd_first_o   current iteration is whitening-only
//   rnd_last_o    current iteration is the final round
//   rnd_dec_o     latched mode
//   busy          controller is not idle
module aes64_round_ctrl
  import aes64_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES64_NUM_ROUNDS
) (
  input  logic                   clk,
  input  logic                   rst,
  aes64_round_ctrl_if.slave      bus,
  output logic [STATE_W-1:0]     rnd_state_o,
  input  logic [STATE_W-1:0]     rnd_result_i,
  output logic [ROUND_IDX_W-1:0] rnd_idx_o,
  output logic                   rnd_first_o,
  output logic                   rnd_last_o,
  output logic                   rnd_dec_o,
  output logic                   busy
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
    $error("aes64_round_ctrl: NUM_ROUNDS must be in 1..15");
  end

  localparam logic [ROUND_IDX_W-1:0] LAST_STEP = ROUND_IDX_W'(NUM_ROUNDS);

  ctrl_state_t             state;
  logic [ROUND_IDX_W-1:0]  step;
  logic [ROUND_IDX_W-1:0]  step_inc;
  logic [STATE_W-1:0]      state_q;
  logic                    dec_q;
  logic [ROUND_IDX_W-1:0]  idx_q;
  logic                    first_q;
  logic                    last_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;

  // Key index for a given step; decrypt walks the schedule backwards.
  // step never exceeds LAST_STEP, so the subtraction cannot wrap.
  function automatic logic [ROUND_IDX_W-1:0] idx_for(
    input logic [ROUND_IDX_W-1:0] s,
    input logic                   dec
  );
    return dec ? ROUND_IDX_W'(LAST_STEP - s) : s;
  endfunction

  assign step_inc = ROUND_IDX_W'(step + 1'b1);

  // Sequencer: index/flag outputs are registered alongside the step they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step        <= '0;
      state_q     <= '0;
      dec_q       <= 1'b0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            state      <= RUN;
            state_q    <= bus.in_data;
            dec_q      <= bus.in_decrypt;
            step       <= '0;
            idx_q      <= idx_for('0, bus.in_decrypt);
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          state_q <= rnd_result_i;
          first_q <= 1'b0;
          if (step == LAST_STEP) begin
            state       <= DONE;
            step        <= '0;
            idx_q       <= idx_for('0, dec_q);
            last_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            step   <= step_inc;
            idx_q  <= idx_for(step_inc, dec_q);
            last_q <= (step_inc == LAST_STEP);
          end
        end
        DONE: begin
          // Result held until the consumer takes it; no accept in this cycle.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = state_q;
  assign rnd_state_o   = state_q;
  assign rnd_dec_o     = dec_q;
  assign rnd_idx_o     = idx_q;
  assign rnd_first_o   = first_q;
  assign rnd_last_o    = last_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_aes64_round_ctrl.sv
// Bench for aes64_round_ctrl with a stub round function
// (next = state + idx + 1) and a loop-based reference model.
module tb_aes64_round_ctrl;
  import aes64_pkg::*;

  localparam int NR = 10;

  logic                   clk;
  logic                   rst;
  logic [STATE_W-1:0]     rnd_state_o;
  logic [STATE_W-1:0]     rnd_result_i;
  logic [ROUND_IDX_W-1:0] rnd_idx_o;
  logic                   rnd_first_o;
  logic                   rnd_last_o;
  logic                   rnd_dec_o;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  aes64_round_ctrl_if bus ();

  aes64_round_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rnd_state_o  (rnd_state_o),
    .rnd_result_i (rnd_result_i),
    .rnd_idx_o    (rnd_idx_o),
    .rnd_first_o  (rnd_first_o),
    .rnd_last_o   (rnd_last_o),
    .rnd_dec_o    (rnd_dec_o),
    .busy         (busy)
  );

  assign rnd_result_i = rnd_state_o + 64'(rnd_idx_o) + 64'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Reference: the k-th iteration uses key k when encrypting, NR-k when decrypting.
  function automatic int model_idx(input int k, input bit dec);
    return dec ? (NR - k) : k;
  endfunction

  function automatic logic [63:0] model_result(input logic [63:0] d, input bit dec);
    logic [63:0] s;
    s = d;
    for (int k = 0; k <= NR; k++) s = s + 64'(model_idx(k, dec)) + 64'd1;
    return s;
  endfunction

  // Offer a block at the next opportunity; returns at the negedge after the accept edge.
  task automatic accept(input logic [63:0] d, input bit dec, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      bus.in_valid   = 1'b1;
      bus.in_data    = d;
      bus.in_decrypt = dec;
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.in_data    = {$urandom, $urandom};
      bus.in_decrypt = 1'($urandom);
    end
  endtask

  task automatic test_reset;
    bit ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (rnd_state_o !== 64'h0) begin errors++; $display("FAIL rst_state got %h exp 0", rnd_state_o); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b exp 1", bus.in_ready); end
    // Reset in the middle of a block discards it.
    accept({$urandom, $urandom}, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_accept timeout got 0 exp 1"); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_block ov/busy/ir got %b%b%b exp 000", bus.out_valid, busy, bus.in_ready); end
    checks++; if (rnd_state_o !== 64'h0 || rnd_dec_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_regs state %h dec %b exp 0 0", rnd_state_o, rnd_dec_o); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release ir/busy/ov got %b%b%b exp 100", bus.in_ready, busy, bus.out_valid); end
    for (int i = 0; i < 14; i++) begin
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_discard cyc %0d out_valid got 1 exp 0", i); end
      @(negedge clk);
    end
  endtask

  task automatic test_encrypt;
    bit ok;
    accept(64'h0, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL enc_accept timeout got 0 exp 1"); end
    for (int k = 0; k <= NR; k++) begin
      checks++; if (rnd_idx_o !== 4'(model_idx(k, 1'b0))) begin errors++; $display("FAIL enc_idx k=%0d got %0d exp %0d", k, rnd_idx_o, model_idx(k, 1'b0)); end
      checks++; if (rnd_first_o !== (k == 0) || rnd_last_o !== (k == NR)) begin
        errors++; $display("FAIL enc_flags k=%0d first/last got %b%b exp %b%b", k, rnd_first_o, rnd_last_o, k == 0, k == NR); end
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL enc_run k=%0d ov/ir/busy got %b%b%b exp 001", k, bus.out_valid, bus.in_ready, busy); end
      @(negedge clk);
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL enc_latency out_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_data !== 64'h42) begin errors++; $display("FAIL enc_data got %h exp 42", bus.out_data); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL enc_release ov/ir got %b%b exp 01", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_decrypt;
    bit ok;
    accept(64'h100, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dec_accept timeout got 0 exp 1"); end
    for (int k = 0; k <= NR; k++) begin
      checks++; if (rnd_idx_o !== 4'(model_idx(k, 1'b1))) begin errors++; $display("FAIL dec_idx k=%0d got %0d exp %0d", k, rnd_idx_o, model_idx(k, 1'b1)); end
      checks++; if (rnd_first_o !== (k == 0) || rnd_last_o !== (k == NR)) begin
        errors++; $display("FAIL dec_flags k=%0d first/last got %b%b exp %b%b", k, rnd_first_o, rnd_last_o, k == 0, k == NR); end
      checks++; if (rnd_dec_o !== 1'b1) begin errors++; $display("FAIL dec_mode k=%0d got %b exp 1", k, rnd_dec_o); end
      @(negedge clk);
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dec_latency out_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_data !== 64'h142) begin errors++; $display("FAIL dec_data got %h exp 142", bus.out_data); end
    checks++; if (rnd_first_o !== 1'b0 || rnd_last_o !== 1'b0) begin
      errors++; $display("FAIL dec_done_flags got %b%b exp 00", rnd_first_o, rnd_last_o); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [63:0] d, exp;
    int lat;
    d = {$urandom, $urandom};
    exp = model_result(d, 1'b0);
    accept(d, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept timeout got 0 exp 1"); end
    lat = 0;
    while (!bus.out_valid && lat < 30) begin @(negedge clk); lat++; end
    checks++; if (lat != NR + 1) begin errors++; $display("FAIL bp_latency got %0d exp %0d", lat, NR + 1); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
        errors++; $display("FAIL bp_hold cyc %0d ov %b data %h exp 1 %h", i, bus.out_valid, bus.out_data, exp); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got 1 exp 0", i); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_same_cycle got 1 exp 0"); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release ir/ov got %b%b exp 10", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_ignored_input;
    bit ok;
    logic [63:0] d;
    d = {$urandom, $urandom};
    accept(d, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_accept timeout got 0 exp 1"); end
    for (int k = 0; k <= NR; k++) begin
      bus.in_valid = (k == 3 || k == 4);
      bus.in_data  = 64'hDEAD;
      checks++; if (rnd_idx_o !== 4'(model_idx(k, 1'b1)) || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL ign_run k=%0d idx %0d ir %b exp %0d 0", k, rnd_idx_o, bus.in_ready, model_idx(k, 1'b1)); end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ign_latency out_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_data !== model_result(d, 1'b1)) begin
      errors++; $display("FAIL ign_data got %h exp %h", bus.out_data, model_result(d, 1'b1)); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle busy got 1 exp 0"); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] blk [2];
    bit          md  [2];
    logic [63:0] res [2];
    int          acc_t [2];
    int nacc, nout;
    bit acc;
    for (int i = 0; i < 2; i++) begin blk[i] = {$urandom, $urandom}; md[i] = 1'($urandom); res[i] = 'x; acc_t[i] = -100; end
    nacc = 0; nout = 0;
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = blk[0];
    bus.in_decrypt = md[0];
    for (int c = 0; c < 40 && nout < 2; c++) begin
      acc = bus.in_valid && bus.in_ready;
      if (acc && nacc < 2) begin acc_t[nacc] = c; nacc++; end
      if (bus.out_valid && nout < 2) begin res[nout] = bus.out_data; nout++; end
      @(negedge clk);
      if (acc) begin
        if (nacc == 1) begin bus.in_data = blk[1]; bus.in_decrypt = md[1]; end
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (nacc != 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", nacc); end
    checks++; if (acc_t[1] - acc_t[0] != NR + 3) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", acc_t[1] - acc_t[0], NR + 3); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (res[i] !== model_result(blk[i], md[i])) begin
        errors++; $display("FAIL b2b_data blk %0d got %h exp %h", i, res[i], model_result(blk[i], md[i])); end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    bit ok, dec;
    logic [63:0] d, exp;
    int lat, hold;
    for (int n = 0; n < 8; n++) begin
      d    = {$urandom, $urandom};
      dec  = 1'($urandom);
      exp  = model_result(d, dec);
      hold = int'($urandom_range(0, 3));
      accept(d, dec, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_accept blk %0d timeout got 0 exp 1", n); end
      lat = 0;
      while (!bus.out_valid && lat < 30) begin @(negedge clk); lat++; end
      checks++; if (lat != NR + 1) begin errors++; $display("FAIL rnd_latency blk %0d got %0d exp %0d", n, lat, NR + 1); end
      repeat (hold) @(negedge clk);
      checks++; if (bus.out_data !== exp || rnd_dec_o !== dec) begin
        errors++; $display("FAIL rnd_data blk %0d got %h dec %b exp %h %b", n, bus.out_data, rnd_dec_o, exp, dec); end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_decrypt = 1'b0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    test_reset;
    test_encrypt;
    test_decrypt;
    test_backpressure;
    test_ignored_input;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
